// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART receive-path encodings and timing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_NINTH = 3'd3;
    localparam logic [2:0] RX_STOP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = RX_IDLE,
        S_START = RX_START,
        S_DATA  = RX_DATA,
        S_NINTH = RX_NINTH,
        S_STOP  = RX_STOP
    } rx_state_e;

    // Terminal tick count and mid-bit sample tick for each oversampling ratio
    localparam logic [2:0] OVS_4 = 3'd3;
    localparam logic [2:0] OVS_3 = 3'd2;
    localparam logic [2:0] MID_4 = 3'd2;
    localparam logic [2:0] MID_3 = 3'd1;

    localparam int FRAME_BITS = 8;

    function automatic logic [2:0] ovs_last(input logic div_sel);
        return div_sel ? OVS_3 : OVS_4;
    endfunction

    function automatic logic [2:0] mid_tick(input logic div_sel);
        return div_sel ? MID_3 : MID_4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : N-stage synchroniser (idle-high) with falling-edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic uart_clk,
    input  logic sys_rstn,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_dly_q;

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync_q     <= '1;
            rx_s_dly_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_s_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o = rx_s_dly_q & ~sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core : oversampling UART receiver with pending/framing/overrun flags
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_core
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = FRAME_BITS
) (
    input  logic              uart_clk,
    input  logic              sys_rstn,
    input  logic              uart_en,
    input  logic              baud_edge,
    input  logic [15:0]       uart_baud,
    input  logic              uart_div_sel,
    input  logic              uart_prty_en,
    input  logic              uart_rx,
    input  logic              rx_pnd_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_9bit,
    output logic              rx_pnd,
    output logic              rx_ferr,
    output logic              rx_ovf,
    output logic              rx_busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .uart_clk (uart_clk),
        .sys_rstn (sys_rstn),
        .rx_i     (uart_rx),
        .rx_s_o   (rx_s),
        .fall_o   (fall)
    );

    rx_state_e         state_q, state_d;
    logic [15:0]       baud_cnt_q, baud_cnt_d;
    logic [2:0]        tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ninth_q, ninth_d;

    logic [DATA_W-1:0] rx_data_q;
    logic              rx_9bit_q, rx_pnd_q, rx_ferr_q, rx_ovf_q;

    logic tick, sample, bit_end, commit;

    assign tick    = baud_edge & (baud_cnt_q == uart_baud) & (state_q != S_IDLE);
    assign sample  = tick & (tick_cnt_q == mid_tick(uart_div_sel));
    assign bit_end = tick & (tick_cnt_q == ovs_last(uart_div_sel));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ninth_d    = ninth_q;
        commit     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_cnt_d = tick ? 16'd0 : baud_cnt_q + {15'd0, baud_edge};
            if (bit_end)
                tick_cnt_d = 3'd0;
            else if (tick)
                tick_cnt_d = tick_cnt_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = 16'd0;
                tick_cnt_d = 3'd0;
                bit_cnt_d  = '0;
                if (fall)
                    state_d = S_START;
            end
            S_START: begin
                if (sample && rx_s)
                    state_d = S_IDLE;
                else if (bit_end)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (sample)
                    shreg_d[bit_cnt_q] = rx_s;
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_W - 1))
                        state_d = uart_prty_en ? S_NINTH : S_STOP;
                end
            end
            S_NINTH: begin
                if (sample)
                    ninth_d = rx_s;
                if (bit_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                // Return at the stop sample so a back-to-back start edge is not missed
                if (sample) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!uart_en) begin
            state_d    = S_IDLE;
            baud_cnt_d = 16'd0;
            tick_cnt_d = 3'd0;
            bit_cnt_d  = '0;
            commit     = 1'b0;
        end
    end

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            tick_cnt_q <= 3'd0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ninth_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ninth_q    <= ninth_d;
        end
    end

    // A commit beats a same-cycle clear on pnd/ferr; the clear always wins on ovf
    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_data_q <= '0;
            rx_9bit_q <= 1'b0;
            rx_pnd_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            if (commit) begin
                rx_data_q <= shreg_q;
                rx_9bit_q <= uart_prty_en & ninth_q;
                rx_ferr_q <= ~rx_s;
                rx_pnd_q  <= 1'b1;
            end else if (rx_pnd_clr) begin
                rx_pnd_q  <= 1'b0;
                rx_ferr_q <= 1'b0;
            end

            if (rx_pnd_clr)
                rx_ovf_q <= 1'b0;
            else if (commit)
                rx_ovf_q <= rx_ovf_q | rx_pnd_q;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_9bit = rx_9bit_q;
    assign rx_pnd  = rx_pnd_q;
    assign rx_ferr = rx_ferr_q;
    assign rx_ovf  = rx_ovf_q;
    assign rx_busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// tb_uart_rx_core : frame table + scoreboard checked at each receiver return
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

    localparam int P = 5;   // uart_clk cycles per baud_edge

    logic        uart_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        uart_en = 1'b0;
    logic        baud_edge = 1'b0;
    logic [15:0] uart_baud = 16'd0;
    logic        uart_div_sel = 1'b0;
    logic        uart_prty_en = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rx_pnd_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_9bit, rx_pnd, rx_ferr, rx_ovf, rx_busy;

    uart_rx_core #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .uart_clk     (uart_clk),
        .sys_rstn     (sys_rstn),
        .uart_en      (uart_en),
        .baud_edge    (baud_edge),
        .uart_baud    (uart_baud),
        .uart_div_sel (uart_div_sel),
        .uart_prty_en (uart_prty_en),
        .uart_rx      (uart_rx),
        .rx_pnd_clr   (rx_pnd_clr),
        .rx_data      (rx_data),
        .rx_9bit      (rx_9bit),
        .rx_pnd       (rx_pnd),
        .rx_ferr      (rx_ferr),
        .rx_ovf       (rx_ovf),
        .rx_busy      (rx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin
        int be_cnt;
        be_cnt = 0;
        forever begin
            @(posedge uart_clk);
            #1;
            be_cnt    = (be_cnt + 1) % P;
            baud_edge = (be_cnt == 0);
        end
    end

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       b9;
        logic       pnd;
        logic       ferr;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        ninth;
        logic        stop;
        logic [15:0] baud;
        logic        div;
        logic        prty;
        logic        clr_before;
        int          gap;
        logic [7:0]  e_data;
        logic        e_9;
        logic        e_pnd;
        logic        e_ferr;
        logic        e_ovf;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_out(input exp_t e);
        n_vec++;
        if (rx_data !== e.data || rx_9bit !== e.b9 || rx_pnd !== e.pnd ||
            rx_ferr !== e.ferr || rx_ovf !== e.ovf) begin
            n_err++;
            $display("FAIL frame%0d: got data=%h 9b=%b pnd=%b ferr=%b ovf=%b, want data=%h 9b=%b pnd=%b ferr=%b ovf=%b",
                     e.id, rx_data, rx_9bit, rx_pnd, rx_ferr, rx_ovf,
                     e.data, e.b9, e.pnd, e.ferr, e.ovf);
        end
    endtask

    // Each return of the receiver to idle retires one scoreboard entry
    initial begin
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge uart_clk);
            if (busy_prev && !rx_busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_return: got data=%h pnd=%b, want no frame end", rx_data, rx_pnd);
                end else begin
                    e = exp_q.pop_front();
                    check_out(e);
                end
            end
            busy_prev = rx_busy;
        end
    end

    task automatic wait_edges(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge uart_clk);
            if (baud_edge) k++;
        end
        #1;
    endtask

    task automatic drain();
        int t;
        exp_t e;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge uart_clk);
            t++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL frame%0d_timeout: got busy=%b, want return to idle", e.id, rx_busy);
        end
        if (t > 0) wait_edges(1);
    endtask

    task automatic pulse_clr();
        @(posedge uart_clk);
        #1 rx_pnd_clr = 1'b1;
        @(posedge uart_clk);
        #1 rx_pnd_clr = 1'b0;
        wait_edges(1);
    endtask

    task automatic send_frame(input vec_t v);
        int epb;
        uart_baud    = v.baud;
        uart_div_sel = v.div;
        uart_prty_en = v.prty;
        epb = (int'(v.baud) + 1) * (v.div ? 3 : 4);
        uart_rx = 1'b0;
        wait_edges(epb);
        for (int i = 0; i < 8; i++) begin
            uart_rx = v.data[i];
            wait_edges(epb);
        end
        if (v.prty) begin
            uart_rx = v.ninth;
            wait_edges(epb);
        end
        uart_rx = v.stop;
        wait_edges(epb);
        uart_rx = 1'b1;
        wait_edges(v.gap * epb);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        //         data   9th   stop  baud    div   prty  clr  gap  e_data 9b   pnd   ferr  ovf
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h55, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h11, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h22, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'h9B, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1, 1'b0, 1, 8'h9B, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (3) @(posedge uart_clk);
        @(negedge uart_clk);
        check_out('{100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        n_vec++;
        if (rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b, want 0", rx_busy);
        end
        @(posedge uart_clk);
        #1 sys_rstn = 1'b1;
        uart_en = 1'b1;
        wait_edges(2);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr_before) pulse_clr();
            exp_q.push_back('{i, tbl[i].e_data, tbl[i].e_9, tbl[i].e_pnd, tbl[i].e_ferr, tbl[i].e_ovf});
            send_frame(tbl[i]);
            drain();
        end

        // Clear acknowledges pending, framing error and overrun together
        pulse_clr();
        @(negedge uart_clk);
        check_out('{101, 8'h9B, 1'b0, 1'b0, 1'b0, 1'b0});
        wait_edges(1);

        // One-edge glitch is rejected at the start sample
        uart_baud = 16'd0; uart_div_sel = 1'b0; uart_prty_en = 1'b0;
        exp_q.push_back('{102, 8'h9B, 1'b0, 1'b0, 1'b0, 1'b0});
        uart_rx = 1'b0;
        wait_edges(1);
        uart_rx = 1'b1;
        wait_edges(12);
        drain();

        // Disable during data bit 3 of 0xF0 discards the partial frame
        uart_rx = 1'b0;
        wait_edges(4);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'b0;
            wait_edges(4);
        end
        uart_rx = 1'b0;
        wait_edges(2);
        @(negedge uart_clk);
        n_vec++;
        if (rx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_mid_frame: got %b, want 1", rx_busy);
        end
        exp_q.push_back('{103, 8'h9B, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge uart_clk);
        #1 uart_en = 1'b0;
        drain();
        uart_rx = 1'b1;
        wait_edges(4);
        uart_en = 1'b1;
        wait_edges(2);

        v = '{8'h0F, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_q.push_back('{104, v.e_data, v.e_9, v.e_pnd, v.e_ferr, v.e_ovf});
        send_frame(v);
        drain();

        v = '{8'hE7, 1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1, 8'hE7, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_q.push_back('{105, v.e_data, v.e_9, v.e_pnd, v.e_ferr, v.e_ovf});
        send_frame(v);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
